move_ctrl: RTL



---
 rtl/move_ctrl_pkg.sv | 19 +
 rtl/move_ctrl_debounce.sv | 57 +++++
 rtl/move_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/move_ctrl_pkg.sv
// Shared definitions for the snake input stage: direction encodings and the
// reversal mask that the game logic also uses.
package move_ctrl_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'b00,
      DIR_RIGHT = 2'b01,
      DIR_DOWN  = 2'b10,
      DIR_LEFT  = 2'b11
   } dir_t;

   // Flipping bit 1 maps each direction onto its opposite.
   localparam logic [1:0] REV_MASK = 2'b10;

   function automatic logic [1:0] reverse_of(input logic [1:0] dir);
      return dir ^ REV_MASK;
   endfunction

endpackage

// File: rtl/move_ctrl_debounce.sv
// btn_debounce: one active-low button -> synchronizer, debounce counter,
// stable pressed level and a one-cycle press pulse (released->pressed only).
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic level,
   output logic press
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_1;
   logic          sync_2;
   logic          pressed_sync;
   logic [CW-1:0] cnt;

   assign pressed_sync = ~sync_2;

   // Two-flop synchronizer on the raw pin; reset value is "released".
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_1 <= 1'b1;
         sync_2 <= 1'b1;
      end else begin
         sync_1 <= btn_n;
         sync_2 <= sync_1;
      end
   end

   // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing cycles;
   // the press pulse fires on the same edge the level goes to pressed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         level <= 1'b0;
         press <= 1'b0;
      end else begin
         press <= 1'b0;
         if (pressed_sync != level) begin
            if (cnt == LAST) begin
               cnt   <= '0;
               level <= pressed_sync;
               press <= pressed_sync;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/move_ctrl.sv
// move_ctrl: debounced direction buttons -> committed snake direction plus a
// step strobe. Priority encoder (up > right > down > left), reversal filter
// against the committed direction, last-wins pending turn, step down-counter.
// Optional feature: define MOVE_SPEEDUP_EN to shorten the step period with
// score; otherwise the period is fixed and score_i is ignored.
module move_ctrl
   import move_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned STEP_CYCLES     = 12500000,
   parameter int unsigned MIN_STEP_CYCLES = 2500000,
   parameter int unsigned SPEED_DELTA     = 40000
) (
   input  logic       clk50m_i,
   input  logic       rst_i,
   input  logic [3:0] btn_n_i,
   input  logic [7:0] score_i,
   output logic [1:0] movement_o,
   output logic       step_o,
   output logic       pending_o
);

   logic [3:0]  press;
   logic [3:0]  level;
   logic        cand_valid;
   logic [1:0]  cand;
   logic        accept;
   logic [1:0]  pend_dir;
   logic [31:0] timer;
   logic [31:0] period;
   logic        step_edge;
   logic        unused_level;

   assign unused_level = ^level;

   for (genvar i = 0; i < 4; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_btn (
         .clk   (clk50m_i),
         .rst   (rst_i),
         .btn_n (btn_n_i[i]),
         .level (level[i]),
         .press (press[i])
      );
   end

   // Fixed-priority pick of one press event per cycle.
   always_comb begin
      cand_valid = 1'b1;
      cand       = DIR_UP;
      if (press[0])      cand = DIR_UP;
      else if (press[1]) cand = DIR_RIGHT;
      else if (press[2]) cand = DIR_DOWN;
      else if (press[3]) cand = DIR_LEFT;
      else               cand_valid = 1'b0;
   end

   // Reversal is judged against the committed direction, never the pending one.
   assign accept    = cand_valid && (cand != reverse_of(movement_o));
   assign step_edge = (timer == 32'd1);

`ifdef MOVE_SPEEDUP_EN
   logic [31:0] prod;

   // Period shrinks with score, saturating at the minimum (including underflow).
   always_comb begin
      prod = 32'(score_i) * SPEED_DELTA;
      if ((prod >= STEP_CYCLES) || ((STEP_CYCLES - prod) < MIN_STEP_CYCLES))
         period = MIN_STEP_CYCLES;
      else
         period = STEP_CYCLES - prod;
   end
`else
   logic unused_score;

   assign unused_score = ^score_i;

   // Fixed period; score has no effect in this build.
   always_comb begin
      period = STEP_CYCLES;
   end
`endif

   // Step timer, pending turn and commit; a same-cycle event joins the commit.
   always_ff @(posedge clk50m_i or posedge rst_i) begin
      if (rst_i) begin
         movement_o <= DIR_RIGHT;
         pend_dir   <= DIR_RIGHT;
         pending_o  <= 1'b0;
         step_o     <= 1'b0;
         timer      <= STEP_CYCLES;
      end else begin
         step_o <= step_edge;
         if (step_edge) begin
            timer     <= period;
            pending_o <= 1'b0;
            if (accept)
               movement_o <= cand;
            else if (pending_o)
               movement_o <= pend_dir;
         end else begin
            timer <= timer - 32'd1;
            if (accept) begin
               pend_dir  <= cand;
               pending_o <= 1'b1;
            end
         end
      end
   end

endmodule
